// File: rtl/muxer_pkg.sv
// Shared types and constants for the N:1 bit muxer with scan-out.
package muxer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/muxer_n.sv
// Generic combinational N:1 bit multiplexer.
module muxer_n #(
  parameter int N = 64,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  in,
  input  logic [SW-1:0] sel,
  output logic          q
);

  assign q = in[sel];

endmodule

// File: rtl/muxer_scan.sv
// N:1 bit muxer with a registered output slot: direct select, or scan-out of a
// snapshot one bit per accepted beat.
// Handshake: a beat transfers on a rising edge where q_valid && q_ready; while
// q_valid && !q_ready, q/q_idx/q_valid hold unchanged.
module muxer_scan
  import muxer_pkg::*;
#(
  parameter int N = 64,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in,
  input  logic [SW-1:0] sel,
  input  logic          mode,
  input  logic          start,
  output logic          q,
  output logic [SW-1:0] q_idx,
  output logic          q_valid,
  input  logic          q_ready,
  output logic          busy,
  output logic          done,
  output scan_state_t   dbg_state
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  scan_state_t   state;
  logic [N-1:0]  snap;
  logic [SW-1:0] cnt;
  logic          slot_free;
  logic [N-1:0]  mux_in;
  logic [SW-1:0] mux_sel;
  logic          mux_q;

  assign slot_free = !q_valid || q_ready;

  // Outside IDLE the live input is ignored; the mux only sees the snapshot.
  assign mux_in  = (state == IDLE) ? in  : snap;
  assign mux_sel = (state == IDLE) ? sel : cnt;

  muxer_n #(.N(N)) u_mux (
    .in  (mux_in),
    .sel (mux_sel),
    .q   (mux_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      snap    <= '0;
      cnt     <= '0;
      q       <= 1'b0;
      q_idx   <= '0;
      q_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mode == MODE_DIRECT) begin
            if (slot_free) begin
              q       <= mux_q;
              q_idx   <= sel;
              q_valid <= 1'b1;
            end
          end else begin
            // A held direct beat survives into SCAN and goes out first.
            if (slot_free) q_valid <= 1'b0;
            if (start) begin
              snap  <= in;
              cnt   <= '0;
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (slot_free) begin
            q       <= mux_q;
            q_idx   <= cnt;
            q_valid <= 1'b1;
            if (cnt == LAST) state <= DRAIN;
            else             cnt   <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (q_valid && q_ready) begin
            q_valid <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_muxer_scan.sv
// Randomized bench for muxer_scan: direct-mode slot model plus a queue of
// expected scan beats derived from the snapshot word.
module tb_muxer_scan;
  import muxer_pkg::*;

  localparam int N  = 64;
  localparam int SW = $clog2(N);
  localparam int BW = SW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  in_w;
  logic [SW-1:0] sel;
  logic          mode;
  logic          start;
  logic          q;
  logic [SW-1:0] q_idx;
  logic          q_valid;
  logic          q_ready;
  logic          busy;
  logic          done;
  scan_state_t   dbg_state;

  muxer_scan #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_w),
    .sel       (sel),
    .mode      (mode),
    .start     (start),
    .q         (q),
    .q_idx     (q_idx),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [BW-1:0] exp_q[$];
  logic          m_valid;
  logic          m_q;
  logic [SW-1:0] m_idx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  function automatic logic [N-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // Direct mode: the slot reloads with in[sel] whenever it is free.
  task automatic direct_cycles(input int n, input int ready_pct, input int pat);
    for (int i = 0; i < n; i++) begin
      mode  = MODE_DIRECT;
      start = 1'b0;
      case (pat)
        1: begin sel = SW'(i); in_w = '0; in_w[sel] = 1'b1; end
        2: begin sel = SW'(i); in_w = '1; in_w[0] = 1'b0; end
        default: begin sel = SW'($urandom_range(0, N - 1)); in_w = rand_word(); end
      endcase
      q_ready = ($urandom_range(0, 99) < ready_pct);
      if (!m_valid || q_ready) begin
        m_q     = in_w[sel];
        m_idx   = sel;
        m_valid = 1'b1;
      end
      @(negedge clk);
      chk("dir_q", q, m_q);
      chk("dir_idx", q_idx, m_idx);
      chk("dir_valid", q_valid, m_valid);
      chk("dir_done", done, 0);
      chk("dir_busy", busy, 0);
    end
  endtask

  // Called at a negedge with the DUT idle.
  task automatic start_scan(input logic [N-1:0] w, input logic ready_at_start);
    mode    = MODE_SCAN;
    start   = 1'b1;
    in_w    = w;
    q_ready = ready_at_start;
    if (m_valid && !q_ready) exp_q.push_back({m_idx, m_q});
    for (int i = 0; i < N; i++) exp_q.push_back({SW'(i), w[i]});
    m_valid = 1'b0;
  endtask

  task automatic run_scan(input int ready_pct, input logic hold_start, input logic toggle_mode,
                          input logic scramble, input int stall_idx);
    logic          last_sent = 1'b0;
    logic          fin = 1'b0;
    logic          stalled = 1'b0;
    logic [SW-1:0] st_idx = '0;
    logic          st_q = 1'b0;
    logic [BW-1:0] e;
    logic [N-1:0]  seen = '0;
    int            beats = 0;
    int            total = exp_q.size();
    int            stall_left = 5;
    for (int cyc = 0; cyc < 8 * N + 50 && !fin; cyc++) begin
      @(negedge clk);
      chk("scan_done", done, last_sent);
      chk("scan_busy", busy, !last_sent);
      if (last_sent) begin
        chk("scan_valid_end", q_valid, 0);
        fin = 1'b1;
      end else begin
        if (stalled) begin
          chk("hold_valid", q_valid, 1);
          chk("hold_idx", q_idx, st_idx);
          chk("hold_q", q, st_q);
        end
        if (stall_idx >= 0 && q_valid && int'(q_idx) == stall_idx && stall_left > 0) begin
          q_ready = 1'b0;
          stall_left--;
        end else begin
          q_ready = ($urandom_range(0, 99) < ready_pct);
        end
        if (q_valid && q_ready) begin
          chk("beat_avail", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat", {q_idx, q}, e);
            if (exp_q.size() == 0) last_sent = 1'b1;
          end
          seen[q_idx] = 1'b1;
          beats++;
        end
        stalled = q_valid && !q_ready;
        st_idx  = q_idx;
        st_q    = q;
        start   = hold_start;
        mode    = toggle_mode ? 1'($urandom_range(0, 1)) : MODE_SCAN;
        if (scramble) in_w = rand_word();
      end
    end
    chk("scan_timeout", fin, 1);
    chk("beat_count", beats, total);
    chk("all_idx", seen, {N{1'b1}});
    start   = 1'b0;
    mode    = MODE_SCAN;
    m_valid = 1'b0;
  endtask

  task automatic reset_mid_scan();
    logic          hit = 1'b0;
    logic [BW-1:0] e;
    start_scan(rand_word(), 1'b1);
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (q_valid && q_idx == SW'(20)) begin
        hit = 1'b1;
      end else begin
        q_ready = 1'b1;
        if (q_valid && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pre_rst_beat", {q_idx, q}, e);
        end
      end
    end
    chk("rst_reach_20", hit, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", q, 0);
    chk("mid_rst_idx", q_idx, 0);
    chk("mid_rst_valid", q_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    exp_q.delete();
    m_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    chk("post_rst_valid", q_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_w = '0; sel = '0; mode = MODE_DIRECT; start = 1'b0; q_ready = 1'b0;
    m_valid = 1'b0; m_q = 1'b0; m_idx = '0;
    #1;
    chk("rst_q", q, 0);
    chk("rst_idx", q_idx, 0);
    chk("rst_valid", q_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    direct_cycles(8, 100, 1);
    direct_cycles(8, 100, 2);
    direct_cycles(20, 100, 0);
    direct_cycles(30, 50, 0);

    start_scan(64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    run_scan(100, 1'b0, 1'b0, 1'b0, -1);

    start_scan(rand_word(), 1'b1);
    run_scan(100, 1'b0, 1'b0, 1'b0, 10);

    start_scan(64'h1, 1'b1);
    run_scan(100, 1'b0, 1'b0, 1'b1, -1);

    direct_cycles(5, 100, 0);
    start_scan(rand_word(), 1'b0);
    run_scan(60, 1'b0, 1'b0, 1'b0, -1);

    start_scan(rand_word(), 1'b1);
    run_scan(70, 1'b1, 1'b1, 1'b1, -1);
    start_scan(rand_word(), 1'b1);
    run_scan(80, 1'b0, 1'b0, 1'b0, -1);

    direct_cycles(10, 70, 0);

    reset_mid_scan();
    start_scan(rand_word(), 1'b1);
    run_scan(100, 1'b0, 1'b0, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
